// File: rtl/restoring_div8x4_if.sv
// -----------------------------------------------------------------------------
// restoring_div8x4_if
//   Start/busy/done handshake and operand/result bus for the restoring divider.
//   master : controlling logic (drives start + operands, observes results)
//   slave  : the divider (observes start + operands, drives results)
// Signals
//   start        request, sampled by the divider only while busy=0
//   dividend     N_W-bit unsigned dividend
//   divisor      D_W-bit unsigned divisor
//   busy         division in progress
//   done         one-cycle pulse, results valid
//   quotient     N_W-bit result, held until the next accepted start
//   remainder    D_W-bit result, held until the next accepted start
//   div_by_zero  captured divisor was zero; held with the results
// -----------------------------------------------------------------------------
interface restoring_div8x4_if #(
    parameter int N_W = 8,
    parameter int D_W = 4
);
    logic           start;
    logic [N_W-1:0] dividend;
    logic [D_W-1:0] divisor;
    logic           busy;
    logic           done;
    logic [N_W-1:0] quotient;
    logic [D_W-1:0] remainder;
    logic           div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_div8x4.sv
// -----------------------------------------------------------------------------
// restoring_div8x4
//   Sequential unsigned restoring divider, one quotient bit per clock.
//   An accepted start latches the operands; N_W RUN cycles later a one-cycle
//   done pulse presents quotient/remainder, which are then held.
// Ports
//   clk  rising-edge clock
//   rst  asynchronous reset, active-high; discards any operation in flight
//   bus  restoring_div8x4_if.slave (start/dividend/divisor in,
//        busy/done/quotient/remainder/div_by_zero out)
// Configuration
//   DIV_ZERO_FAST_EN  defined: a zero divisor completes straight from IDLE,
//                     done on the cycle after the start edge, busy never set.
//                     undefined: a zero divisor runs the full sequence and
//                     the forced results are substituted at completion.
// -----------------------------------------------------------------------------
module restoring_div8x4 #(
    parameter int N_W = 8,
    parameter int D_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    restoring_div8x4_if.slave   bus
);
    localparam int CW = $clog2(N_W + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_nx;
    logic           accept, last;
`ifdef DIV_ZERO_FAST_EN
    logic           zero_fast;
`endif

    logic [N_W-1:0] q_r;        // shifting dividend / quotient register
    logic [D_W:0]   p_r;        // partial remainder, one guard bit wide
    logic [D_W-1:0] dvs_r;      // captured divisor
    logic [D_W-1:0] dvd_lo;     // captured dividend low bits (div-by-zero remainder)
    logic [CW-1:0]  count;

    logic           done_r, dbz_r;
    logic [N_W-1:0] quo_r;
    logic [D_W-1:0] rem_r;

    logic [D_W:0]   p_sh, p_nx;
    logic [D_W+1:0] diff;
    logic [N_W-1:0] q_nx;

    // ---------------- one restoring iteration ----------------
    always_comb begin
        p_sh = {p_r[D_W-1:0], q_r[N_W-1]};
        // One extra bit so the MSB of the difference is the borrow.
        diff = {1'b0, p_sh} - {2'b00, dvs_r};
        p_nx = diff[D_W+1] ? p_sh : diff[D_W:0];
        q_nx = {q_r[N_W-2:0], ~diff[D_W+1]};
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
`ifdef DIV_ZERO_FAST_EN
        zero_fast = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.divisor == '0) zero_fast = 1'b1;
                    else                   state_nx  = RUN;
`else
                    state_nx = RUN;
`endif
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    last     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- datapath / results ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r    <= '0;
            p_r    <= '0;
            dvs_r  <= '0;
            dvd_lo <= '0;
            count  <= '0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            quo_r  <= '0;
            rem_r  <= '0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                q_r    <= bus.dividend;
                dvs_r  <= bus.divisor;
                dvd_lo <= bus.dividend[D_W-1:0];
                p_r    <= '0;
                count  <= CW'(N_W);
                dbz_r  <= 1'b0;
            end
`ifdef DIV_ZERO_FAST_EN
            // Later assignment wins over the dbz clear above.
            if (zero_fast) begin
                done_r <= 1'b1;
                quo_r  <= '1;
                rem_r  <= bus.dividend[D_W-1:0];
                dbz_r  <= 1'b1;
            end
`endif
            if (state == RUN) begin
                q_r   <= q_nx;
                p_r   <= p_nx;
                count <= count - CW'(1);
                if (last) begin
                    done_r <= 1'b1;
                    if (dvs_r == '0) begin
                        quo_r <= '1;
                        rem_r <= dvd_lo;
                        dbz_r <= 1'b1;
                    end else begin
                        quo_r <= q_nx;
                        rem_r <= p_nx[D_W-1:0];
                    end
                end
            end
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = done_r;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_restoring_div8x4.sv
module tb_restoring_div8x4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    restoring_div8x4_if bus ();
    restoring_div8x4 dut (.clk(clk), .rst(rst), .bus(bus));

    // Edges between the accepting edge and the done cycle.
`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 8;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive start for one edge; returns 1ns after the accepting edge.
    task automatic launch(input logic [7:0] a, input logic [3:0] b, input bit keep);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #1;
        if (!keep) bus.start = 1'b0;
    endtask

    // Wait (bounded) for done; optionally poke start with other operands
    // poke edges after the accept. Checks latency and results.
    task automatic wait_done(input string tag, input int elat,
                             input logic [7:0] eq, input logic [3:0] er, input logic ez,
                             input int poke, input logic [7:0] pa, input logic [3:0] pb,
                             input bit hold);
        int n = 0;
        bit seen = bus.done;
        while (!seen && n < 20) begin
            if (poke != 0 && n == poke) begin
                bus.start = 1'b1; bus.dividend = pa; bus.divisor = pb;
            end
            if (poke != 0 && n == poke + 1 && !hold) bus.start = 1'b0;
            @(posedge clk); #1;
            n++;
            seen = bus.done;
        end
        chk({tag, " latency"}, n, elat);
        chk({tag, " quotient"}, bus.quotient, eq);
        chk({tag, " remainder"}, bus.remainder, er);
        chk({tag, " div_by_zero"}, bus.div_by_zero, ez);
        chk({tag, " busy at done"}, bus.busy, 1'b0);
    endtask

    // One cycle after done: pulse gone, results held.
    task automatic after_done(input string tag, input logic [7:0] eq, input logic [3:0] er);
        @(posedge clk); #1;
        chk({tag, " done pulse"}, bus.done, 1'b0);
        chk({tag, " held quotient"}, bus.quotient, eq);
        chk({tag, " held remainder"}, bus.remainder, er);
    endtask

    initial begin
        int dcount;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        #12;
        chk("reset busy", bus.busy, 1'b0);
        chk("reset done", bus.done, 1'b0);
        chk("reset quotient", bus.quotient, 8'd0);
        chk("reset remainder", bus.remainder, 4'd0);
        chk("reset dbz", bus.div_by_zero, 1'b0);
        @(negedge clk); rst = 1'b0;

        launch(8'd200, 4'd7, 1'b0);
        chk("200/7 busy", bus.busy, 1'b1);
        wait_done("200/7", 8, 8'd28, 4'd4, 1'b0, 0, 8'd0, 4'd0, 1'b0);
        after_done("200/7", 8'd28, 4'd4);

        launch(8'd225, 4'd15, 1'b0);
        wait_done("225/15", 8, 8'd15, 4'd0, 1'b0, 0, 8'd0, 4'd0, 1'b0);
        launch(8'd255, 4'd1, 1'b0);
        wait_done("255/1", 8, 8'd255, 4'd0, 1'b0, 0, 8'd0, 4'd0, 1'b0);
        launch(8'd0, 4'd9, 1'b0);
        wait_done("0/9", 8, 8'd0, 4'd0, 1'b0, 0, 8'd0, 4'd0, 1'b0);
        launch(8'd6, 4'd13, 1'b0);
        wait_done("6/13", 8, 8'd0, 4'd6, 1'b0, 0, 8'd0, 4'd0, 1'b0);
        after_done("6/13", 8'd0, 4'd6);

        launch(8'd5, 4'd0, 1'b0);
        chk("5/0 busy", bus.busy, (ZLAT != 0) ? 1'b1 : 1'b0);
        wait_done("5/0", ZLAT, 8'hFF, 4'd5, 1'b1, 0, 8'd0, 4'd0, 1'b0);
        after_done("5/0", 8'hFF, 4'd5);
        chk("5/0 dbz held", bus.div_by_zero, 1'b1);

        // start while busy is ignored; dbz clears on the accept
        launch(8'd100, 4'd3, 1'b0);
        chk("100/3 dbz cleared", bus.div_by_zero, 1'b0);
        wait_done("100/3", 8, 8'd33, 4'd1, 1'b0, 3, 8'd50, 4'd5, 1'b0);
        after_done("100/3", 8'd33, 4'd1);

        // async reset mid-division
        launch(8'd200, 4'd7, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst busy", bus.busy, 1'b0);
        chk("midrst done", bus.done, 1'b0);
        chk("midrst quotient", bus.quotient, 8'd0);
        chk("midrst remainder", bus.remainder, 4'd0);
        chk("midrst dbz", bus.div_by_zero, 1'b0);
        @(negedge clk); rst = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done) dcount++;
        end
        chk("midrst no done", dcount, 0);
        launch(8'd9, 4'd2, 1'b0);
        wait_done("9/2", 8, 8'd4, 4'd1, 1'b0, 0, 8'd0, 4'd0, 1'b0);

        // back-to-back: start held high through done with new operands
        launch(8'd200, 4'd7, 1'b0);
        wait_done("b2b first", 8, 8'd28, 4'd4, 1'b0, 3, 8'd77, 4'd8, 1'b1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b accept done", bus.done, 1'b0);
        chk("b2b accept busy", bus.busy, 1'b1);
        wait_done("b2b second", 8, 8'd9, 4'd5, 1'b0, 0, 8'd0, 4'd0, 1'b0);
        after_done("b2b second", 8'd9, 4'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
